// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - Iterative RV32M multiply/divide unit (option: MULDIV_FAST_MUL_EN single-cycle multiply)
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic [4:0]      rd_in,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]        state;
    logic [5:0]        cnt;
    logic [2*XLEN-1:0] acc;
    logic [XLEN:0]     rem;
    logic [XLEN-1:0]   mag_a;
    logic [XLEN-1:0]   mag_b;
    logic [2:0]        op_q;
    logic              neg_q;
    logic [4:0]        rd_q;

    // Capture-side decode: signedness, magnitudes and short-circuit detection
    logic            a_signed;
    logic            b_signed;
    logic            sign_a;
    logic            sign_b;
    logic [XLEN-1:0] cap_mag_a;
    logic [XLEN-1:0] cap_mag_b;
    logic            div_zero;
    logic            div_ovf;
    logic [XLEN-1:0] short_res;

    assign a_signed  = (funct3 != 3'b011) && (funct3 != 3'b101) && (funct3 != 3'b111);
    assign b_signed  = (funct3 == 3'b000) || (funct3 == 3'b001) ||
                       (funct3 == 3'b100) || (funct3 == 3'b110);
    assign sign_a    = a_signed & op_a[XLEN-1];
    assign sign_b    = b_signed & op_b[XLEN-1];
    assign cap_mag_a = sign_a ? -op_a : op_a;
    assign cap_mag_b = sign_b ? -op_b : op_b;
    assign div_zero  = funct3[2] && (op_b == {XLEN{1'b0}});
    assign div_ovf   = ((funct3 == 3'b100) || (funct3 == 3'b110)) &&
                       (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == {XLEN{1'b1}});
    // Overflow quotient equals the most-negative dividend itself
    assign short_res = div_zero ? (funct3[1] ? op_a : {XLEN{1'b1}})
                                : (funct3[1] ? {XLEN{1'b0}} : op_a);

`ifdef MULDIV_FAST_MUL_EN
    logic signed [2*XLEN-1:0] fast_a;
    logic signed [2*XLEN-1:0] fast_b;
    logic signed [2*XLEN-1:0] fast_p;
    logic [XLEN-1:0]          fast_word;

    assign fast_a    = {{XLEN{sign_a}}, op_a};
    assign fast_b    = {{XLEN{sign_b}}, op_b};
    assign fast_p    = fast_a * fast_b;
    assign fast_word = (funct3[1:0] == 2'b00) ? fast_p[XLEN-1:0] : fast_p[2*XLEN-1:XLEN];
`endif

    // Shift-add step: multiplier sits in the low half and drains LSB first
    logic [XLEN:0] mul_sum;
    assign mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mag_a} : {(XLEN+1){1'b0}});

    // Restoring step: dividend bits leave acc MSB first, quotient bits enter at the LSB
    logic [XLEN+1:0] rem_shift;
    logic [XLEN:0]   rem_diff;
    logic            q_bit;
    assign rem_shift = {rem, acc[XLEN-1]};
    assign q_bit     = rem_shift >= {2'b00, mag_b};
    assign rem_diff  = rem_shift[XLEN:0] - {1'b0, mag_b};

    logic [2*XLEN-1:0] mul_fix;
    logic [XLEN-1:0]   quo_fix;
    logic [XLEN-1:0]   rem_fix;
    logic [XLEN-1:0]   fix_word;

    assign mul_fix  = neg_q ? -acc : acc;
    assign quo_fix  = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    assign rem_fix  = neg_q ? -rem[XLEN-1:0] : rem[XLEN-1:0];
    assign fix_word = op_q[2] ? (op_q[1] ? rem_fix : quo_fix)
                              : ((op_q[1:0] == 2'b00) ? mul_fix[XLEN-1:0] : mul_fix[2*XLEN-1:XLEN]);

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            cnt    <= 6'd0;
            acc    <= {(2*XLEN){1'b0}};
            rem    <= {(XLEN+1){1'b0}};
            mag_a  <= {XLEN{1'b0}};
            mag_b  <= {XLEN{1'b0}};
            op_q   <= 3'b000;
            neg_q  <= 1'b0;
            rd_q   <= 5'd0;
            result <= {XLEN{1'b0}};
            rd_out <= 5'd0;
        end else begin
            case (state)
                S_CALC: begin
                    if (op_q[2]) begin
                        rem <= q_bit ? rem_diff : rem_shift[XLEN:0];
                        acc <= {acc[2*XLEN-1:XLEN], acc[XLEN-2:0], q_bit};
                    end else begin
                        acc <= {mul_sum, acc[XLEN-1:1]};
                    end
                    cnt <= cnt + 6'd1;
                    if (cnt == 6'd31) begin
                        state <= S_FIX;
                    end
                end
                S_FIX: begin
                    result <= fix_word;
                    rd_out <= rd_q;
                    cnt    <= 6'd0;
                    state  <= S_DONE;
                end
                default: begin
                    // IDLE and DONE accept a new request identically
                    if (start) begin
                        op_q  <= funct3;
                        rd_q  <= rd_in;
                        neg_q <= (funct3[2] && funct3[1]) ? sign_a : (sign_a ^ sign_b);
                        mag_a <= cap_mag_a;
                        mag_b <= cap_mag_b;
                        cnt   <= 6'd0;
                        rem   <= {(XLEN+1){1'b0}};
                        acc   <= {{XLEN{1'b0}}, (funct3[2] ? cap_mag_a : cap_mag_b)};
                        if (div_zero || div_ovf) begin
                            result <= short_res;
                            rd_out <= rd_in;
                            state  <= S_DONE;
`ifdef MULDIV_FAST_MUL_EN
                        end else if (!funct3[2]) begin
                            result <= fast_word;
                            rd_out <= rd_in;
                            state  <= S_DONE;
`endif
                        end else begin
                            state <= S_CALC;
                        end
                    end else begin
                        state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign busy = (state == S_CALC) || (state == S_FIX);
    assign done = (state == S_DONE);

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - Self-checking bench for muldiv_unit against an arithmetic reference model
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] op_a = 32'd0;
    logic [31:0] op_b = 32'd0;
    logic [4:0]  rd_in = 5'd0;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [4:0]  rd_out;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    typedef struct {
        int          k;
        int          lat;
        logic [31:0] res;
        logic [4:0]  rd;
    } op_t;

    op_t         q[$];
    logic [31:0] last_res = 32'd0;
    logic [4:0]  last_rd = 5'd0;
    int          last_done_cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    muldiv_unit #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .start(start), .funct3(funct3),
        .op_a(op_a), .op_b(op_b), .rd_in(rd_in),
        .busy(busy), .done(done), .result(result), .rd_out(rd_out)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        logic [63:0]        ua;
        logic [63:0]        ub;
        logic [63:0]        p;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (f)
            3'd0, 3'd1: p = sa * sb;
            3'd2:       p = sa * $signed(ub);
            3'd3:       p = ua * ub;
            3'd4: if (b == 32'd0) p = 64'hFFFFFFFF; else p = sa / sb;
            3'd5: if (b == 32'd0) p = 64'hFFFFFFFF; else p = ua / ub;
            3'd6: if (b == 32'd0) p = ua; else p = sa % sb;
            default: if (b == 32'd0) p = ua; else p = ua % ub;
        endcase
        if (f == 3'd1 || f == 3'd2 || f == 3'd3) return p[63:32];
        return p[31:0];
    endfunction

    function automatic int lat_of(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (f[2] && b == 32'd0) return 1;
        if ((f == 3'd4 || f == 3'd6) && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
`ifdef MULDIV_FAST_MUL_EN
        if (!f[2]) return 1;
`endif
        return 34;
    endfunction

    // Every cycle: busy/done follow the in-flight operation's schedule; result/rd_out checked at done
    always @(negedge clk) begin : cmp
        logic eb;
        logic ed;
        eb = 1'b0;
        ed = 1'b0;
        if (cyc > 0) begin
            if (!rst && q.size() > 0) begin
                ed = (cyc == q[0].k + q[0].lat - 1);
                eb = (q[0].lat > 1) && (cyc >= q[0].k) && (cyc < q[0].k + q[0].lat - 1);
            end
            chk("busy", {31'd0, busy}, {31'd0, eb});
            chk("done", {31'd0, done}, {31'd0, ed});
            if (ed) begin
                chk("result", result, q[0].res);
                chk("rd_out", {27'd0, rd_out}, {27'd0, q[0].rd});
                last_res = result;
                last_rd = rd_out;
                last_done_cyc = cyc;
                void'(q.pop_front());
            end
        end
    end

    // Called just after a falling edge; the request is sampled at the next rising edge
    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        op_t o;
        funct3 = f;
        op_a = a;
        op_b = b;
        rd_in = rd;
        start = 1'b1;
        o.k = cyc + 1;
        o.lat = lat_of(f, a, b);
        o.res = model(f, a, b);
        o.rd = rd;
        q.push_back(o);
        @(negedge clk);
        #1;
        start = 1'b0;
        op_a = $urandom;
        op_b = $urandom;
        funct3 = 3'($urandom_range(0, 7));
        rd_in = 5'($urandom_range(0, 31));
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (q.size() != 0 && n < 80) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL timeout: done not seen, want done within 80 cycles");
            q.delete();
        end
    endtask

    task automatic run(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] lit);
        chk("model_pin", model(f, a, b), lit);
        issue(f, a, b, rd);
        wait_done();
        chk("literal", last_res, lit);
    endtask

    initial begin
        int first_done;
        int k0;
        logic [2:0]  rf;
        logic [31:0] ra;
        logic [31:0] rb;

        repeat (3) @(negedge clk);
        chk("rst_result", result, 32'd0);
        chk("rst_rd_out", {27'd0, rd_out}, 32'd0);
        #1;
        rst = 1'b0;
        @(negedge clk);
        #1;

        run(3'd0, 32'd7, 32'hFFFFFFFA, 5'd5, 32'hFFFFFFD6);
        chk("mul_rd", {27'd0, last_rd}, 32'd5);
        run(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1, 32'hFFFFFFFE);
        run(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2, 32'h00000000);
        run(3'd2, 32'hFFFFFFFF, 32'd2, 5'd3, 32'hFFFFFFFF);
        run(3'd4, 32'hFFFFFFF9, 32'd2, 5'd4, 32'hFFFFFFFD);
        run(3'd6, 32'hFFFFFFF9, 32'd2, 5'd6, 32'hFFFFFFFF);
        run(3'd5, 32'd100, 32'd7, 5'd7, 32'd14);
        run(3'd7, 32'd100, 32'd7, 5'd8, 32'd2);

        // Reset in the middle of CALC: outputs clear and the abandoned op never completes
        issue(3'd4, 32'd1000, 32'd7, 5'd13);
        repeat (9) @(negedge clk);
        #1;
        rst = 1'b1;
        q.delete();
        @(negedge clk);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_done", {31'd0, done}, 32'd0);
        chk("midrst_result", result, 32'd0);
        #1;
        rst = 1'b0;
        repeat (40) @(negedge clk);
        #1;
        run(3'd5, 32'd9, 32'd3, 5'd14, 32'd3);

        run(3'd5, 32'd5, 32'd0, 5'd9, 32'hFFFFFFFF);
        run(3'd6, 32'd5, 32'd0, 5'd10, 32'd5);
        run(3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd11, 32'h80000000);
        run(3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd12, 32'd0);
        run(3'd4, 32'hFFFFFFF9, 32'd0, 5'd15, 32'hFFFFFFFF);
        run(3'd0, 32'h80000000, 32'h80000000, 5'd16, 32'd0);
        run(3'd1, 32'h80000000, 32'h80000000, 5'd17, 32'h40000000);

        // Back-to-back with an ignored mid-CALC request
        issue(3'd4, 32'd100, 32'd7, 5'd18);
        k0 = cyc;
        repeat (4) @(negedge clk);
        #1;
        funct3 = 3'd3;
        op_a = 32'h12345678;
        op_b = 32'h9ABCDEF0;
        rd_in = 5'd30;
        start = 1'b1;
        @(negedge clk);
        #1;
        start = 1'b0;
        repeat (28) @(negedge clk);
        #1;
        chk("b2b_first_at", last_done_cyc - k0, 32'd33);
        first_done = last_done_cyc;
        issue(3'd7, 32'd10, 32'd3, 5'd19);
        wait_done();
        chk("b2b_result", last_res, 32'd1);
        chk("b2b_gap", last_done_cyc - first_done, 32'd34);

        for (int i = 0; i < 12; i++) begin
            rf = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = (i % 4 == 0) ? 32'($urandom_range(0, 2)) : $urandom;
            issue(rf, ra, rb, 5'(i + 1));
            wait_done();
        end

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
